// File: rtl/data_memory_sync_pkg.sv
// Shared definitions for the synchronous data memory: FSM encoding and default geometry.
package data_memory_sync_pkg;

  // Defaults shared with the datapath.
  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefAddrWidth = 12;

  typedef enum logic {
    MemInit  = 1'b0,
    MemReady = 1'b1
  } mem_state_e;

endpackage

// File: rtl/data_memory_lane.sv
// One byte-wide RAM slice with its own write enable. The read port is combinational, and the
// top level registers the result.
module data_memory_lane #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4096
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem [DEPTH];

  // Array write. The caller keeps we low for out-of-range addresses.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_sync.sv
// Single-port data memory with byte-lane writes, post-reset zero-fill, read-during-write
// forwarding and an out-of-range address flag.
module data_memory_sync
  import data_memory_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DEPTH      = 4096,
  localparam int unsigned LANES     = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [LANES-1:0]      byte_en,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  ready,
  output logic                  addr_error
);

  // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable without wrapping.
  localparam logic [ADDR_WIDTH:0] DepthW = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LastW  = DepthW - 1'b1;

  mem_state_e state_q, state_d;
  logic [ADDR_WIDTH:0] init_cnt_q, init_cnt_d;

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  addr_error_q, addr_error_d;

  logic                  in_range;
  logic                  rd_acc, wr_acc;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [LANES-1:0]      lane_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;

  assign ready    = (state_q == MemReady);
  assign in_range = ({1'b0, address} < DepthW);
  assign rd_acc   = ready & mem_read;
  assign wr_acc   = ready & mem_write;

  // RAM port steering: the fill counter owns the port until READY.
  always_comb begin
    ram_addr  = init_cnt_q[ADDR_WIDTH-1:0];
    ram_wdata = '0;
    lane_we   = '1;
    if (ready) begin
      ram_addr  = address;
      ram_wdata = data_in;
      lane_we   = (wr_acc && in_range) ? byte_en : '0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    data_memory_lane #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH     (DEPTH)
    ) u_lane (
      .clock(clock),
      .we   (lane_we[i]),
      .addr (ram_addr),
      .wdata(ram_wdata[8*i +: 8]),
      .rdata(rd_word[8*i +: 8])
    );
  end

  // Forwarding merge: a same-cycle write shows up in the read result lane by lane.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < LANES; i++) begin
      if (wr_acc && byte_en[i]) begin
        merged[8*i +: 8] = data_in[8*i +: 8];
      end
    end
  end

  // Zero-fill FSM next state: walk every word once, then stay in READY until reset.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      MemInit: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LastW) begin
          state_d = MemReady;
        end
      end
      MemReady: begin
        state_d = MemReady;
      end
      default: state_d = MemInit;
    endcase
  end

  // Output next state: data_out only changes on an accepted read.
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = rd_acc;
    addr_error_d = (rd_acc | wr_acc) & ~in_range;
    if (rd_acc) begin
      data_out_d = in_range ? merged : '0;
    end
  end

  // FSM and fill counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= MemInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Output registers; a reset drops any read result in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      addr_error_q <= addr_error_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign addr_error = addr_error_q;

endmodule

// File: tb/tb_data_memory_sync.sv
// Bench for data_memory_sync: a full-depth instance and a DEPTH=3000 instance share stimulus;
// expected outputs come from word-array models and flow through a scoreboard queue.
module tb_data_memory_sync;

  localparam int unsigned DepthA = 4096;
  localparam int unsigned DepthB = 3000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  byte_en = 2'b00;
  logic [11:0] address = '0;
  logic [15:0] data_in = '0;

  logic [15:0] dout_a, dout_b;
  logic        valid_a, valid_b, ready_a, ready_b, err_a, err_b;

  data_memory_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .DEPTH(DepthA)) dut_a (
    .clock(clock), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .byte_en(byte_en), .address(address), .data_in(data_in), .data_out(dout_a),
    .data_valid(valid_a), .ready(ready_a), .addr_error(err_a)
  );

  data_memory_sync #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .DEPTH(DepthB)) dut_b (
    .clock(clock), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .byte_en(byte_en), .address(address), .data_in(data_in), .data_out(dout_b),
    .data_valid(valid_b), .ready(ready_b), .addr_error(err_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] da;
    logic        va;
    logic        ea;
    logic [15:0] db;
    logic        vb;
    logic        eb;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_a [DepthA];
  logic [15:0] model_b [DepthA];
  logic [15:0] hold_a, hold_b;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0] = din[7:0];
    if (be[1]) r[15:8] = din[15:8];
    return r;
  endfunction

  task automatic clear_models();
    for (int i = 0; i < int'(DepthA); i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end
    hold_a = '0;
    hold_b = '0;
  endtask

  // One command cycle: predict, push, clock, pop, compare.
  task automatic do_cycle(input string tag, input logic rd, input logic wr,
                          input logic [1:0] be, input logic [11:0] addr, input logic [15:0] din);
    exp_t        e;
    exp_t        got;
    logic [15:0] nw;
    logic        in_a, in_b;
    in_a = int'(addr) < int'(DepthA);
    in_b = int'(addr) < int'(DepthB);
    nw = wr ? merge(model_a[addr], din, be) : model_a[addr];
    if (rd) hold_a = in_a ? nw : 16'h0000;
    if (wr && in_a) model_a[addr] = nw;
    nw = wr ? merge(model_b[addr], din, be) : model_b[addr];
    if (rd) hold_b = in_b ? nw : 16'h0000;
    if (wr && in_b) model_b[addr] = nw;
    e.da = hold_a; e.va = rd; e.ea = (rd | wr) & ~in_a;
    e.db = hold_b; e.vb = rd; e.eb = (rd | wr) & ~in_b;
    sb_q.push_back(e);
    mem_read = rd; mem_write = wr; byte_en = be; address = addr; data_in = din;
    @(posedge clock);
    #1;
    mem_read = 1'b0; mem_write = 1'b0; byte_en = 2'b00;
    if (sb_q.size() == 0) begin
      check_val({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check_val({tag, ".a_data"},  {16'h0, dout_a}, {16'h0, got.da});
      check_val({tag, ".a_valid"}, {31'h0, valid_a}, {31'h0, got.va});
      check_val({tag, ".a_err"},   {31'h0, err_a},   {31'h0, got.ea});
      check_val({tag, ".b_data"},  {16'h0, dout_b}, {16'h0, got.db});
      check_val({tag, ".b_valid"}, {31'h0, valid_b}, {31'h0, got.vb});
      check_val({tag, ".b_err"},   {31'h0, err_b},   {31'h0, got.eb});
    end
  endtask

  // Asserts reset between edges and checks the immediate output values.
  task automatic assert_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_val({tag, ".valid"}, {30'h0, valid_a, valid_b}, 32'd0);
    check_val({tag, ".dout"},  {dout_a, dout_b}, 32'd0);
    check_val({tag, ".ready"}, {30'h0, ready_a, ready_b}, 32'd0);
    check_val({tag, ".err"},   {30'h0, err_a, err_b}, 32'd0);
    mem_read = 1'b0; mem_write = 1'b0;
    clear_models();
  endtask

  // Releases reset on a falling edge and counts edges until each instance is ready.
  // Optionally issues commands mid-fill, which must be dropped.
  task automatic release_and_fill(input string tag, input bit inject, input int abort_at);
    int cnt_a = 0;
    int cnt_b = 0;
    int quiet_bad = 0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 1; c <= 4200; c++) begin
      @(posedge clock);
      #1;
      if (valid_a | valid_b | err_a | err_b) quiet_bad++;
      if (cnt_a == 0 && ready_a) cnt_a = c;
      if (cnt_b == 0 && ready_b) cnt_b = c;
      if (inject && c == 10) begin
        mem_write = 1'b1; mem_read = 1'b1; byte_en = 2'b11;
        address = 12'h005; data_in = 16'hFFFF;
      end
      if (inject && c == 12) begin
        mem_write = 1'b0; mem_read = 1'b0; byte_en = 2'b00;
      end
      if (abort_at != 0 && c == abort_at) begin
        check_val({tag, ".mid_ready"}, {30'h0, ready_a, ready_b}, 32'd0);
        return;
      end
      if (cnt_a != 0 && cnt_b != 0) break;
    end
    check_val({tag, ".fill_a"}, cnt_a, DepthA);
    check_val({tag, ".fill_b"}, cnt_b, DepthB);
    check_val({tag, ".quiet"}, quiet_bad, 0);
  endtask

  initial begin
    clear_models();
    #2;
    assert_reset("rst0");
    repeat (3) @(posedge clock);
    release_and_fill("init0", 1'b0, 0);

    do_cycle("s1_rd001",  1'b1, 1'b0, 2'b00, 12'h001, 16'h0000);
    do_cycle("s2_wr002",  1'b0, 1'b1, 2'b11, 12'h002, 16'hBEEF);
    do_cycle("s2_rd002",  1'b1, 1'b0, 2'b00, 12'h002, 16'h0000);
    do_cycle("hold",      1'b0, 1'b0, 2'b00, 12'h000, 16'h0000);
    do_cycle("s3_wr002",  1'b0, 1'b1, 2'b01, 12'h002, 16'h1234);
    do_cycle("s3_rd002",  1'b1, 1'b0, 2'b00, 12'h002, 16'h0000);
    do_cycle("s4_rw003",  1'b1, 1'b1, 2'b11, 12'h003, 16'hA5A5);
    do_cycle("s4_rd003",  1'b1, 1'b0, 2'b00, 12'h003, 16'h0000);
    do_cycle("fwd_hi004", 1'b1, 1'b1, 2'b10, 12'h004, 16'h7788);
    do_cycle("be0_004",   1'b0, 1'b1, 2'b00, 12'h004, 16'hFFFF);
    do_cycle("rd004",     1'b1, 1'b0, 2'b00, 12'h004, 16'h0000);
    do_cycle("s5_wrBB8",  1'b0, 1'b1, 2'b11, 12'hBB8, 16'hFFFF);
    do_cycle("s5_rdBB8",  1'b1, 1'b0, 2'b00, 12'hBB8, 16'h0000);
    do_cycle("s5_rd000",  1'b1, 1'b0, 2'b00, 12'h000, 16'h0000);
    do_cycle("wrBB7",     1'b0, 1'b1, 2'b11, 12'hBB7, 16'h1111);
    do_cycle("rdBB7",     1'b1, 1'b0, 2'b00, 12'hBB7, 16'h0000);
    do_cycle("rwFFF",     1'b1, 1'b1, 2'b11, 12'hFFF, 16'h5A5A);
    do_cycle("rdFFF",     1'b1, 1'b0, 2'b00, 12'hFFF, 16'h0000);

    // Reset with a read command set up but not yet sampled.
    mem_read = 1'b1; address = 12'h002;
    #3;
    assert_reset("rst_pend");
    release_and_fill("init1", 1'b1, 0);
    do_cycle("r6_rd002", 1'b1, 1'b0, 2'b00, 12'h002, 16'h0000);
    do_cycle("r6_rd005", 1'b1, 1'b0, 2'b00, 12'h005, 16'h0000);

    // Reset while a read result is being presented.
    do_cycle("r6_wr003", 1'b0, 1'b1, 2'b11, 12'h003, 16'hC3C3);
    do_cycle("r6_rd003", 1'b1, 1'b0, 2'b00, 12'h003, 16'h0000);
    assert_reset("rst_valid");

    // Reset mid-fill, then the fill must restart from word 0 and take the full count.
    release_and_fill("init2", 1'b0, 100);
    assert_reset("rst_mid");
    release_and_fill("init3", 1'b0, 0);
    do_cycle("r6_rd003b", 1'b1, 1'b0, 2'b00, 12'h003, 16'h0000);
    do_cycle("r6_rd004",  1'b1, 1'b0, 2'b00, 12'h004, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
